// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell per clock, registered borrow.
// Computes a - b - bin over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             br, msb_a, msb_b;
  logic [CW-1:0]    cnt;

  logic             d, br_next, last;
  logic [WIDTH-1:0] acc_next;

  // One full-subtractor cell on the current LSBs.
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
    acc_next = {d, acc[WIDTH-1:1]};
    last     = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      br    <= 1'b0;
      msb_a <= 1'b0;
      msb_b <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            msb_a <= a[WIDTH-1];
            msb_b <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        SHIFT: begin
          br  <= br_next;
          acc <= acc_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          // Results latch on the edge entering DONE from the final cell's
          // outputs, so they are already valid during the done cycle.
          if (last) begin
            diff <= acc_next;
            bout <= br_next;
            zero <= (acc_next == '0);
            ovf  <= (msb_a != msb_b) & (acc_next[WIDTH-1] != msb_a);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, handshake corner
// cases and random operands at WIDTH=8, plus an exhaustive sweep at WIDTH=3.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8, ovf8, zero8;
  logic [7:0] a8, b8, diff8;
  logic       start3, bin3, busy3, done3, bout3, ovf3, zero3;
  logic [2:0] a3, b3, diff3;

  int   checks = 0;
  int   errors = 0;
  res_t last8;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3), .zero(zero3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word.
  function automatic res_t model(input int w, input int ta, input int tb, input int tbin);
    res_t r;
    int   m, raw, d;
    m      = 1 << w;
    raw    = ta - tb - tbin;
    d      = (raw + m) % m;
    r.diff = 8'(d);
    r.bout = (raw < 0);
    r.ovf  = ((ta >= m / 2) != (tb >= m / 2)) && ((d >= m / 2) != (ta >= m / 2));
    r.zero = (d == 0);
    return r;
  endfunction

  // Issues one op (possibly in a DONE cycle) and ends in its own done cycle.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input res_t e, input int glitch_at, input string tag);
    int k, busy_n;
    bit moved;
    busy_n = 0;
    moved  = 0;
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(posedge clk); #1;
    k = 1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    while (!done8 && k < 20) begin
      if (busy8) busy_n++;
      if (diff8 !== last8.diff || bout8 !== last8.bout || ovf8 !== last8.ovf || zero8 !== last8.zero)
        moved = 1;
      if (k == glitch_at) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h01; bin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start8 = 1'b0;
    check({tag, "_latency"}, k, 9);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_busy_at_done"}, busy8, 0);
    check({tag, "_held_while_busy"}, moved, 0);
    check({tag, "_diff"}, diff8, e.diff);
    check({tag, "_bout"}, bout8, e.bout);
    check({tag, "_ovf"}, ovf8, e.ovf);
    check({tag, "_zero"}, zero8, e.zero);
    last8 = e;
  endtask

  task automatic idle8(input string tag);
    start8 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done8, 0);
    check({tag, "_hold_diff"}, diff8, last8.diff);
    check({tag, "_hold_flags"}, {bout8, ovf8, zero8}, {last8.bout, last8.ovf, last8.zero});
  endtask

  task automatic op3(input int ta, input int tb, input int tbin);
    res_t e;
    int   k;
    e  = model(3, ta, tb, tbin);
    a3 = 3'(ta); b3 = 3'(tb); bin3 = 1'(tbin); start3 = 1'b1;
    @(posedge clk); #1;
    k = 1;
    start3 = 1'b0;
    while (!done3 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("w3_latency", k, 4);
    check("w3_result", {diff3, bout3, ovf3, zero3}, {e.diff[2:0], e.bout, e.ovf, e.zero});
  endtask

  initial begin
    vec_t vecs[7];
    res_t e, zero_res;
    int   k;
    bit   seen;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    zero_res = '{8'h00, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_w8", {busy8, done8, diff8, bout8, ovf8, zero8}, 0);
    check("reset_w3", {busy3, done3, diff3, bout3, ovf3, zero3}, 0);
    last8 = zero_res;

    // Directed vectors, each followed by an idle cycle.
    for (int i = 0; i < 7; i++) begin
      e = '{vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero};
      op8(vecs[i].a, vecs[i].b, vecs[i].bin, e, 0, $sformatf("vec%0d", i));
      idle8($sformatf("vec%0d", i));
    end

    // Start mid-op is ignored; then a start in the DONE cycle chains directly.
    op8(8'h35, 8'h12, 1'b0, '{8'h23, 1'b0, 1'b0, 1'b0}, 3, "ignore_mid_start");
    op8(8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b0}, 0, "back_to_back");
    idle8("back_to_back");

    // Reset in the middle of SHIFT aborts with no done pulse.
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_outputs", {diff8, bout8, ovf8, zero8}, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) seen = 1;
    end
    check("abort_no_done", seen, 0);
    last8 = zero_res;
    op8(8'h35, 8'h12, 1'b0, '{8'h23, 1'b0, 1'b0, 1'b0}, 0, "after_abort");
    idle8("after_abort");

    // Reset wins over a simultaneous start.
    rst = 1'b1; start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    check("rst_vs_start_busy", busy8, 0);
    check("rst_vs_start_outputs", {diff8, bout8, ovf8, zero8}, 0);
    last8 = zero_res;
    k = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy8 || done8) k++;
    end
    check("rst_vs_start_stays_idle", k, 0);

    // Random operands, mixing chained and gapped issue.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 16 == 0) rb = ra;
      op8(ra, rb, rbin, model(8, int'(ra), int'(rb), int'(rbin)), 0, "rand");
      if ($urandom_range(0, 1) == 1) idle8("rand");
    end

    // WIDTH=3 exhaustive sweep, issued back-to-back.
    for (int ta = 0; ta < 8; ta++)
      for (int tb = 0; tb < 8; tb++)
        for (int tbin = 0; tbin < 2; tbin++)
          op3(ta, tb, tbin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
